usb_tx_wire_arbiter: RTL and testbench

Arbitrates between three transmit-side requesters that share the single USB wire write port in the serial interface engine. The three requesters are:

- the SIE packet transmitter (sie),
- the process-TX-byte bit stuffer (ptb),
- the line-control block that drives reset/resume/idle signalling (lc).

Exactly one requester owns the wire-write port at a time. The block sequences ownership with a req/gnt handshake, steers the owner's 2-bit line state and drive-enable onto the shared port, and gates the write-ready flag back to the owner only. It sits between those three blocks and the wire write buffer.

---
 rtl/usb_tx_wire_arbiter.sv | 165 ++++++++++++++++
 tb/tb_usb_tx_wire_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_wire_arbiter.sv
// Shares the single USB wire write port between the SIE transmitter, the bit stuffer and line control.
// One owner at a time; the owner's line state, drive flag and write strobe are steered onto the port.
module usb_tx_wire_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sieReq,
    input  logic       ptbReq,
    input  logic       lcReq,
    output logic       sieGnt,
    output logic       ptbGnt,
    output logic       lcGnt,
    input  logic [1:0] sieTxBits,
    input  logic [1:0] ptbTxBits,
    input  logic [1:0] lcTxBits,
    input  logic       sieTxCtrl,
    input  logic       ptbTxCtrl,
    input  logic       lcTxCtrl,
    input  logic       sieWEn,
    input  logic       ptbWEn,
    input  logic       lcWEn,
    output logic       sieRdy,
    output logic       ptbRdy,
    output logic       lcRdy,
    output logic [1:0] TxBits,
    output logic       TxCtrl,
    output logic       WireWEn,
    input  logic       WireRdy,
    output logic [1:0] dbgState
);

    // Handshake: a requester holds req high for as long as it needs the port; gnt rises one
    // cycle after req is sampled in IDLE and falls one cycle after the owner drops req. While
    // granted, a write happens on every cycle where the owner's WEn is high; the owner only
    // strobes WEn when its Rdy (WireRdy gated by its own gnt) is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [1:0] SIE = 2'd0;
    localparam logic [1:0] PTB = 2'd1;
    localparam logic [1:0] LC  = 2'd2;

    state_t     state, stateNext;
    logic [1:0] owner, ownerNext;
    logic [1:0] lastOwner, lastOwnerNext;
    logic [2:0] gnt, gntNext;
    logic [2:0] req;
    logic [1:0] winner;
    logic       ownerReq;

    assign req = {lcReq, ptbReq, sieReq};

    // Winner is only meaningful when some req is high.
    always_comb begin
        winner = SIE;
        if (FIXED_PRIORITY) begin
            if (lcReq)       winner = LC;
            else if (sieReq) winner = SIE;
            else             winner = PTB;
        end else begin
            case (lastOwner)
                SIE:     winner = ptbReq ? PTB : (lcReq  ? LC  : SIE);
                PTB:     winner = lcReq  ? LC  : (sieReq ? SIE : PTB);
                default: winner = sieReq ? SIE : (ptbReq ? PTB : LC);
            endcase
        end
    end

    always_comb begin
        case (owner)
            SIE:     ownerReq = sieReq;
            PTB:     ownerReq = ptbReq;
            LC:      ownerReq = lcReq;
            default: ownerReq = 1'b0;
        endcase
    end

    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        lastOwnerNext = lastOwner;
        gntNext       = gnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    gntNext       = 3'b001 << winner;
                    ownerNext     = winner;
                    lastOwnerNext = winner;
                    stateNext     = GNT;
                end
            end
            GNT: begin
                if (!ownerReq) begin
                    gntNext   = 3'b000;
                    stateNext = REL;
                end
            end
            REL: begin
                stateNext = IDLE;
            end
            default: begin
                gntNext   = 3'b000;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= SIE;
            lastOwner <= LC;
            gnt       <= 3'b000;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastOwner <= lastOwnerNext;
            gnt       <= gntNext;
        end
    end

    // Port mux: only the registered owner reaches the wire buffer, and only in GNT.
    always_comb begin
        TxBits  = 2'b00;
        TxCtrl  = 1'b0;
        WireWEn = 1'b0;
        if (state == GNT) begin
            case (owner)
                SIE: begin
                    TxBits  = sieTxBits;
                    TxCtrl  = sieTxCtrl;
                    WireWEn = sieWEn;
                end
                PTB: begin
                    TxBits  = ptbTxBits;
                    TxCtrl  = ptbTxCtrl;
                    WireWEn = ptbWEn;
                end
                LC: begin
                    TxBits  = lcTxBits;
                    TxCtrl  = lcTxCtrl;
                    WireWEn = lcWEn;
                end
                default: begin
                    TxBits  = 2'b00;
                    TxCtrl  = 1'b0;
                    WireWEn = 1'b0;
                end
            endcase
        end
    end

    assign sieGnt   = gnt[0];
    assign ptbGnt   = gnt[1];
    assign lcGnt    = gnt[2];
    assign sieRdy   = WireRdy & gnt[0];
    assign ptbRdy   = WireRdy & gnt[1];
    assign lcRdy    = WireRdy & gnt[2];
    assign dbgState = state;

endmodule

// File: tb/tb_usb_tx_wire_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter from the same requesters and compares
// both against an ownership model built from the grant/release timing rules.
module tb_usb_tx_wire_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] req, wen, ctrl;
    logic [1:0] bits [3];
    logic       wireRdy;

    wire [2:0] gnt0, rdy0, gnt1, rdy1;
    wire [1:0] txb0, txb1, st0, st1;
    wire       txc0, txc1, wwe0, wwe1;

    usb_tx_wire_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .sieReq(req[0]), .ptbReq(req[1]), .lcReq(req[2]),
        .sieGnt(gnt0[0]), .ptbGnt(gnt0[1]), .lcGnt(gnt0[2]),
        .sieTxBits(bits[0]), .ptbTxBits(bits[1]), .lcTxBits(bits[2]),
        .sieTxCtrl(ctrl[0]), .ptbTxCtrl(ctrl[1]), .lcTxCtrl(ctrl[2]),
        .sieWEn(wen[0]), .ptbWEn(wen[1]), .lcWEn(wen[2]),
        .sieRdy(rdy0[0]), .ptbRdy(rdy0[1]), .lcRdy(rdy0[2]),
        .TxBits(txb0), .TxCtrl(txc0), .WireWEn(wwe0), .WireRdy(wireRdy),
        .dbgState(st0)
    );

    usb_tx_wire_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .sieReq(req[0]), .ptbReq(req[1]), .lcReq(req[2]),
        .sieGnt(gnt1[0]), .ptbGnt(gnt1[1]), .lcGnt(gnt1[2]),
        .sieTxBits(bits[0]), .ptbTxBits(bits[1]), .lcTxBits(bits[2]),
        .sieTxCtrl(ctrl[0]), .ptbTxCtrl(ctrl[1]), .lcTxCtrl(ctrl[2]),
        .sieWEn(wen[0]), .ptbWEn(wen[1]), .lcWEn(wen[2]),
        .sieRdy(rdy1[0]), .ptbRdy(rdy1[1]), .lcRdy(rdy1[2]),
        .TxBits(txb1), .TxCtrl(txc1), .WireWEn(wwe1), .WireRdy(wireRdy),
        .dbgState(st1)
    );

    int total = 0;
    int bad   = 0;

    // Model per instance: current owner (-1 none), a one-edge hold-off after a release, last owner.
    int own  [2] = '{-1, -1};
    int hold [2] = '{0, 0};
    int last [2] = '{2, 2};

    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int fp, input int lst, input logic [2:0] r);
        if (fp != 0) begin
            if (r[2]) return 2;
            if (r[0]) return 0;
            return 1;
        end
        for (int d = 1; d <= 3; d++) begin
            int c;
            c = (lst + d) % 3;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                own[k] = -1; hold[k] = 0; last[k] = 2;
            end else if (own[k] >= 0) begin
                if (!req[own[k]]) begin
                    own[k] = -1; hold[k] = 1;
                end
            end else if (hold[k] != 0) begin
                hold[k] = 0;
            end else if (req != 3'b000) begin
                own[k] = pick(k, last[k], req);
                last[k] = own[k];
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [2:0] eg;
            logic [1:0] eb, es;
            logic       ec, ew;
            eg = 3'b000; eb = 2'b00; ec = 1'b0; ew = 1'b0;
            if (own[k] >= 0) begin
                eg = 3'b001 << own[k];
                eb = bits[own[k]];
                ec = ctrl[own[k]];
                ew = wen[own[k]];
            end
            es = (own[k] >= 0) ? 2'd1 : ((hold[k] != 0) ? 2'd2 : 2'd0);
            chk($sformatf("gnt%0d", k),  (k == 0) ? gnt0 : gnt1, eg);
            chk($sformatf("rdy%0d", k),  (k == 0) ? rdy0 : rdy1, eg & {3{wireRdy}});
            chk($sformatf("bits%0d", k), (k == 0) ? txb0 : txb1, eb);
            chk($sformatf("ctrl%0d", k), (k == 0) ? txc0 : txc1, ec);
            chk($sformatf("wen%0d", k),  (k == 0) ? wwe0 : wwe1, ew);
            chk($sformatf("state%0d", k), (k == 0) ? st0 : st1, es);
        end
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = 3'b000; wen = 3'b000; ctrl = 3'b000; wireRdy = 1'b0;
        for (int i = 0; i < 3; i++) bits[i] = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt1();
        int n;
        n = 0;
        while (gnt1 == 3'b000 && n < 10) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] g, prev_g;
        int gap, ngr, nwr, idx;

        clear_inputs();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_gnt0", gnt0, 3'b000);
        chk("rst_gnt1", gnt1, 3'b000);
        chk("rst_wen", wwe0, 1'b0);
        chk("rst_state", st0, 2'd0);

        // Single requester, then a write steered to the port in the same cycle.
        req = 3'b001;
        step();
        chk("t1_gnt", gnt0, 3'b001);
        wireRdy = 1'b1; wen[0] = 1'b1; bits[0] = 2'b10; ctrl[0] = 1'b1;
        #1;
        chk("t1_wwe", wwe0, 1'b1);
        chk("t1_bits", txb0, 2'b10);
        chk("t1_ctrl", txc0, 1'b1);
        step();

        // Ready gating for the owner only.
        wen[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wireRdy = (i != 1);
            #1;
            chk("t5_sierdy", rdy0, {2'b00, wireRdy});
            step();
        end

        // Round-robin rotation with four writes per ownership.
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        wireRdy = 1'b1;
        req = 3'b111;
        prev_g = 3'b000; gap = 0; ngr = 0; nwr = 0;
        for (int cyc = 0; cyc < 100 && ngr < 4; cyc++) begin
            wen = 3'b000;
            req = 3'b111;
            if (own[0] >= 0) begin
                if (nwr < 4) begin
                    wen[own[0]] = 1'b1;
                    bits[own[0]] = 2'($urandom_range(0, 3));
                    nwr++;
                end else begin
                    req[own[0]] = 1'b0;
                end
            end
            step();
            g = gnt0;
            if (g != 3'b000 && prev_g == 3'b000) begin
                idx = g[0] ? 0 : (g[1] ? 1 : 2);
                if (exp_q.size() > 0) chk("rr_order", idx, exp_q.pop_front());
                if (ngr > 0) chk("rr_gap", gap, 2);
                ngr++; gap = 0; nwr = 0;
            end else if (g == 3'b000) begin
                gap++;
            end
            prev_g = g;
        end
        chk("rr_count", ngr, 4);

        // Fixed priority: lc, then sie, then ptb.
        do_reset();
        req = 3'b111;
        step();
        chk("fp_first", gnt1, 3'b100);
        req[2] = 1'b0;
        step();
        wait_gnt1();
        chk("fp_second", gnt1, 3'b001);
        req[0] = 1'b0;
        step();
        wait_gnt1();
        chk("fp_third", gnt1, 3'b010);

        // Non-owner strobes never reach the port.
        do_reset();
        req = 3'b010;
        step();
        req = 3'b011;
        wireRdy = 1'b1;
        wen[1] = 1'b1; bits[1] = 2'b11; ctrl[1] = 1'b0;
        wen[0] = 1'b1; bits[0] = 2'b01; ctrl[0] = 1'b1;
        #1;
        chk("t4_wwe", wwe0, 1'b1);
        chk("t4_bits", txb0, 2'b11);
        chk("t4_ctrl", txc0, 1'b0);
        chk("t4_sierdy", rdy0[0], 1'b0);
        step();
        wen[1] = 1'b0;
        #1;
        chk("t4_wwe_off", wwe0, 1'b0);
        step();

        // Reset during lc ownership drops the grant at once and restores lastOwner.
        do_reset();
        req = 3'b100;
        step();
        chk("t6_lc", gnt0, 3'b100);
        wen[2] = 1'b1; bits[2] = 2'b11; ctrl[2] = 1'b1; wireRdy = 1'b1;
        rst = 1'b1;
        step();
        chk("t6_gnt", gnt0, 3'b000);
        chk("t6_bits", txb0, 2'b00);
        chk("t6_ctrl", txc0, 1'b0);
        chk("t6_wen", wwe0, 1'b0);
        rst = 1'b0;
        req = 3'b101;
        step();
        chk("t6_rr_sie", gnt0, 3'b001);
        chk("t6_fp_lc", gnt1, 3'b100);

        // Random traffic with occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                bits[i] = 2'($urandom_range(0, 3));
            end
            wen     = 3'($urandom_range(0, 7));
            ctrl    = 3'($urandom_range(0, 7));
            wireRdy = 1'($urandom_range(0, 1));
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
